// File: rtl/twitch_mem_pkg.sv
// Shared constants, port-FSM encoding and fault decode for the twitchcore unified memory.
package twitch_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  localparam int WAIT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } port_state_e;

  // A data access faults when its size is reserved or the address is not naturally aligned.
  function automatic logic access_faults(input logic [1:0] size, input logic [1:0] addr_lo);
    logic f;
    f = 1'b0;
    case (size)
      SZ_HALF: f = addr_lo[0];
      SZ_WORD: f = (addr_lo != 2'b00);
      SZ_RSVD: f = 1'b1;
      default: f = 1'b0;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/twitch_mem_port.sv
// Per-port handshake: IDLE/WAIT/RESP FSM, wait down-counter and registered response.
module twitch_mem_port
  import twitch_mem_pkg::*;
#(
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [31:0] rsp_data,
  input  logic        rsp_fault,
  output logic        ready,
  output logic        valid,
  output logic [31:0] data,
  output logic        fault
);

  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(WAIT_STATES);

  port_state_e       state_q, state_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic [31:0]       data_q, data_d;
  logic              fault_q, fault_d;
  logic              accept;

  assign ready  = (state_q != ST_WAIT);
  assign accept = req && ready;

  // The response is captured at the accepting edge; RESP is the cycle it is presented.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    fault_d = fault_q;
    if (accept) begin
      data_d  = rsp_data;
      fault_d = rsp_fault;
    end
    case (state_q)
      ST_WAIT: begin
        if (cnt_q <= WAIT_W'(1)) begin
          state_d = ST_RESP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        if (accept) begin
          if (WAIT_STATES == 0) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_LOAD;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      fault_q <= fault_d;
    end
  end

  assign valid = (state_q == ST_RESP);
  assign data  = data_q;
  assign fault = fault_q;

endmodule

// File: rtl/twitch_mem2p.sv
// Dual-port unified memory for twitchcore: word fetch port I and byte/half/word load/store port D.
// Note: resetn is ACTIVE-HIGH despite its name; the array itself is never cleared.
module twitch_mem2p
  import twitch_mem_pkg::*;
#(
  parameter int    ADDR_BITS   = 14,
  parameter int    WAIT_STATES = 0,
  parameter string INIT_FILE   = ""
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 i_req,
  input  logic [ADDR_BITS-1:0] i_addr,
  output logic                 i_ready,
  output logic                 i_valid,
  output logic [31:0]          i_data,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [1:0]           d_size,
  input  logic                 d_unsigned,
  input  logic [ADDR_BITS-1:0] d_addr,
  input  logic [31:0]          d_wdata,
  output logic                 d_ready,
  output logic                 d_valid,
  output logic [31:0]          d_rdata,
  output logic                 d_fault
);

  localparam int WORD_BITS = ADDR_BITS - 2;
  localparam int DEPTH     = 1 << WORD_BITS;

  logic [31:0] mem [DEPTH];

  logic [WORD_BITS-1:0] i_idx, d_idx;
  logic [31:0]          i_rd_word, d_rd_word;
  logic                 d_fault_now, d_wr_en;
  logic [3:0]           wr_be;
  logic [31:0]          wr_lanes;
  logic [7:0]           ld_byte;
  logic [15:0]          ld_half;
  logic [31:0]          ld_ext, d_rsp;
  logic                 i_fault_unused;
  logic                 unused_addr_bits;

  assign i_idx       = i_addr[ADDR_BITS-1:2];
  assign d_idx       = d_addr[ADDR_BITS-1:2];
  assign i_rd_word   = mem[i_idx];
  assign d_rd_word   = mem[d_idx];
  assign d_fault_now = access_faults(d_size, d_addr[1:0]);
  assign d_wr_en     = d_req && d_ready && d_we && !d_fault_now;

  // Store data is right-aligned, so replicate it across lanes and let the byte enables pick.
  always_comb begin
    wr_be    = 4'b0000;
    wr_lanes = d_wdata;
    case (d_size)
      SZ_BYTE: begin
        wr_be    = 4'b0001 << d_addr[1:0];
        wr_lanes = {4{d_wdata[7:0]}};
      end
      SZ_HALF: begin
        wr_be    = d_addr[1] ? 4'b1100 : 4'b0011;
        wr_lanes = {2{d_wdata[15:0]}};
      end
      SZ_WORD: begin
        wr_be    = 4'b1111;
        wr_lanes = d_wdata;
      end
      default: begin
        wr_be    = 4'b0000;
        wr_lanes = d_wdata;
      end
    endcase
  end

  // Reads sample the pre-write contents, so a same-edge fetch of a stored word sees old data.
  always_ff @(posedge clk) begin
    if (d_wr_en) begin
      for (int lane = 0; lane < 4; lane++) begin
        if (wr_be[lane]) mem[d_idx][lane*8 +: 8] <= wr_lanes[lane*8 +: 8];
      end
    end
  end

  always_comb begin
    ld_byte = d_rd_word[{d_addr[1:0], 3'b000} +: 8];
    ld_half = d_addr[1] ? d_rd_word[31:16] : d_rd_word[15:0];
    case (d_size)
      SZ_BYTE: ld_ext = {{24{~d_unsigned & ld_byte[7]}}, ld_byte};
      SZ_HALF: ld_ext = {{16{~d_unsigned & ld_half[15]}}, ld_half};
      default: ld_ext = d_rd_word;
    endcase
    d_rsp = (d_we || d_fault_now) ? 32'h0 : ld_ext;
  end

  twitch_mem_port #(.WAIT_STATES(WAIT_STATES)) u_port_i (
    .clk      (clk),
    .rst      (resetn),
    .req      (i_req),
    .rsp_data (i_rd_word),
    .rsp_fault(1'b0),
    .ready    (i_ready),
    .valid    (i_valid),
    .data     (i_data),
    .fault    (i_fault_unused)
  );

  twitch_mem_port #(.WAIT_STATES(WAIT_STATES)) u_port_d (
    .clk      (clk),
    .rst      (resetn),
    .req      (d_req),
    .rsp_data (d_rsp),
    .rsp_fault(d_fault_now),
    .ready    (d_ready),
    .valid    (d_valid),
    .data     (d_rdata),
    .fault    (d_fault)
  );

  assign unused_addr_bits = ^{i_addr[1:0], i_fault_unused};

endmodule
